// File: rtl/mult_8bit_seq.sv
// Sequential unsigned 8x8 shift-and-add multiplier with a start/busy/done handshake.
// Each iteration adds M into the accumulator through one adder_8bit, then shifts {C,A,Q} right.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] soma,
  output logic       cout,
  output logic       ovf
);
  logic [7:0] w_b;

  // cin=1 turns the stage into a - b (two's complement: invert b, add one)
  assign w_b          = b ^ {8{cin}};
  assign {cout, soma} = {1'b0, a} + {1'b0, w_b} + {8'd0, cin};
  assign ovf          = (a[7] == w_b[7]) && (soma[7] != a[7]);
endmodule

module mult_8bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_m, r_a, r_q;
  logic        r_c;
  logic [3:0]  r_cnt;
  logic [15:0] r_product;
  logic        r_busy, r_done;

  logic [7:0]  w_m_nxt, w_a_nxt, w_q_nxt;
  logic        w_c_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] w_product_nxt;
  logic [7:0]  w_soma;
  logic        w_cout;
  logic [8:0]  w_acc;

  adder_8bit u_adder (
    .a    (r_a),
    .b    (r_m),
    .cin  (1'b0),
    .soma (w_soma),
    .cout (w_cout),
    .ovf  ()
  );

  // post-add {C,A}; the shift below drops it one place into {A,Q}
  assign w_acc = r_q[0] ? {w_cout, w_soma} : {1'b0, r_a};

  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_a_nxt       = r_a;
    w_q_nxt       = r_q;
    w_c_nxt       = r_c;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_m_nxt     = a;
          w_q_nxt     = b;
          w_a_nxt     = 8'd0;
          w_c_nxt     = 1'b0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_c_nxt   = 1'b0;
        w_a_nxt   = w_acc[8:1];
        w_q_nxt   = {w_acc[0], r_q[7:1]};
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd7) begin
          w_product_nxt = {w_acc, r_q[7:1]};
          w_state_nxt   = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= 8'd0;
      r_a       <= 8'd0;
      r_q       <= 8'd0;
      r_c       <= 1'b0;
      r_cnt     <= 4'd0;
      r_product <= 16'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_a       <= w_a_nxt;
      r_q       <= w_q_nxt;
      r_c       <= w_c_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule
